// File: rtl/ame_result_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ame_result_writer: writes latched solver results as single-beat AXI4     |
// | writes to base + 8*idx.                              Revision 1.0        |
// +--------------------------------------------------------------------------+
module ame_result_writer #(
   parameter int DATA_BITS = 64,
   parameter int ADDR_BITS = 32,
   parameter int NUM_WORDS = 6
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                start_i,
   input  logic [ADDR_BITS-1:0]                base_addr_i,
   input  logic                                affine_param6_i,
   input  logic [NUM_WORDS-1:0][DATA_BITS-1:0] data_i,
   output logic                                busy_o,
   output logic                                done_o,
   output logic                                err_o,
   output logic [ADDR_BITS-1:0]                m_axi_awaddr,
   output logic [7:0]                          m_axi_awlen,
   output logic [2:0]                          m_axi_awsize,
   output logic [1:0]                          m_axi_awburst,
   output logic                                m_axi_awvalid,
   input  logic                                m_axi_awready,
   output logic [DATA_BITS-1:0]                m_axi_wdata,
   output logic [DATA_BITS/8-1:0]              m_axi_wstrb,
   output logic                                m_axi_wlast,
   output logic                                m_axi_wvalid,
   input  logic                                m_axi_wready,
   input  logic [1:0]                          m_axi_bresp,
   input  logic                                m_axi_bvalid,
   output logic                                m_axi_bready
);

   localparam int                  IDX_BITS = $clog2(NUM_WORDS);
   localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_XFER = 2'd1,
      S_RESP = 2'd2
   } state_e;

   state_e                              state_q, state_d;
   logic [IDX_BITS-1:0]                 idx_q, idx_d;
   logic [ADDR_BITS-1:0]                base_q, base_d;
   logic [NUM_WORDS-1:0][DATA_BITS-1:0] data_q, data_d;
   logic                                busy_q, busy_d;
   logic                                done_q, done_d;
   logic                                err_q, err_d;
   logic                                awvalid_q, awvalid_d;
   logic                                wvalid_q, wvalid_d;
   logic [ADDR_BITS-1:0]                awaddr_q, awaddr_d;
   logic [DATA_BITS-1:0]                wdata_q, wdata_d;

   logic [IDX_BITS-1:0] first_idx;
   logic [IDX_BITS-1:0] idx_next;
   logic                aw_ok;
   logic                w_ok;

   function automatic logic [ADDR_BITS-1:0] addr_of(input logic [ADDR_BITS-1:0] base,
                                                    input logic [IDX_BITS-1:0]  idx);
      return base + (ADDR_BITS'(idx) << 3);
   endfunction

   assign first_idx = affine_param6_i ? IDX_BITS'(0) : IDX_BITS'(2);
   assign idx_next  = idx_q + 1'b1;
   // A channel counts as complete once its valid is low (already handshaken) or is being taken now.
   assign aw_ok     = !awvalid_q || m_axi_awready;
   assign w_ok      = !wvalid_q  || m_axi_wready;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         base_q    <= '0;
         data_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         base_q    <= base_d;
         data_q    <= data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      base_d    = base_q;
      data_d    = data_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = err_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      case (state_q)
         S_IDLE: begin
            // busy stays high through the done_o cycle so a coincident start is dropped.
            if (busy_q) begin
               busy_d = 1'b0;
            end else if (start_i) begin
               data_d    = data_i;
               base_d    = base_addr_i;
               idx_d     = first_idx;
               awaddr_d  = addr_of(base_addr_i, first_idx);
               wdata_d   = data_i[first_idx];
               err_d     = 1'b0;
               busy_d    = 1'b1;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               state_d   = S_XFER;
            end
         end
         S_XFER: begin
            if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
            if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
            if (aw_ok && w_ok)              state_d   = S_RESP;
         end
         S_RESP: begin
            if (m_axi_bvalid) begin
               if (m_axi_bresp != 2'b00) err_d = 1'b1;
               if (idx_q == LAST_IDX) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  idx_d     = idx_next;
                  awaddr_d  = addr_of(base_q, idx_next);
                  wdata_d   = data_q[idx_next];
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = S_XFER;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign err_o         = err_q;
   assign m_axi_awaddr  = awaddr_q;
   assign m_axi_awlen   = 8'h00;
   assign m_axi_awsize  = 3'h3;
   assign m_axi_awburst = 2'h1;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = '1;
   assign m_axi_wlast   = wvalid_q;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_bready  = (state_q == S_RESP);

endmodule
`default_nettype wire

// File: tb/tb_ame_result_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ame_result_writer: directed bench with an AXI write slave model.      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_ame_result_writer;

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b1;
   logic              start_i = 1'b0;
   logic [31:0]       base_addr_i = '0;
   logic              affine_param6_i = 1'b0;
   logic [5:0][63:0]  data_i = '0;
   logic              busy_o, done_o, err_o;
   logic [31:0]       awaddr;
   logic [7:0]        awlen;
   logic [2:0]        awsize;
   logic [1:0]        awburst;
   logic              awvalid, wvalid, wlast, bready;
   logic [63:0]       wdata;
   logic [7:0]        wstrb;
   logic              awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
   logic [1:0]        bresp = 2'b00;

   int checks = 0, failures = 0;
   int aw_delay = 0, w_delay = 0, err_at = -1;
   int aw_wait = 0, w_wait = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
   int cyc = 0, last_b_cyc = 0, viol = 0;
   bit cur_aw = 0, cur_w = 0, aw_pend = 0, w_pend = 0;
   logic [31:0] addr_log [0:63];
   logic [63:0] data_log [0:63];

   ame_result_writer dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
      .affine_param6_i(affine_param6_i), .data_i(data_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
      .m_axi_awburst(awburst), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
      .m_axi_wvalid(wvalid), .m_axi_wready(wready),
      .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready)
   );

   always #5 clk_i = ~clk_i;

   // Slave: records handshakes and flags withdrawn valids or a second AW before B.
   always @(posedge clk_i) begin
      cyc++;
      if (rst_i) begin
         cur_aw = 0; cur_w = 0; aw_pend = 0; w_pend = 0; aw_wait = 0; w_wait = 0;
      end else begin
         if (aw_pend && !awvalid) viol++;
         if (w_pend && !wvalid) viol++;
         if (awvalid && awready) begin
            if (cur_aw) viol++;
            if (aw_cnt < 64) addr_log[aw_cnt] = awaddr;
            aw_cnt++; cur_aw = 1; aw_wait = 0;
         end else if (awvalid) aw_wait++;
         else aw_wait = 0;
         if (wvalid && wready) begin
            if (cur_w) viol++;
            if (w_cnt < 64) data_log[w_cnt] = wdata;
            w_cnt++; cur_w = 1; w_wait = 0;
         end else if (wvalid) w_wait++;
         else w_wait = 0;
         aw_pend = awvalid && !awready;
         w_pend  = wvalid && !wready;
         if (bvalid && bready) begin
            b_cnt++; last_b_cyc = cyc; cur_aw = 0; cur_w = 0;
         end
      end
   end

   always @(negedge clk_i) begin
      awready = awvalid && (aw_wait >= aw_delay);
      wready  = wvalid && (w_wait >= w_delay);
      bvalid  = cur_aw && cur_w;
      bresp   = (b_cnt == err_at) ? 2'b10 : 2'b00;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_job(input logic [31:0] base, input logic p6, input logic [5:0][63:0] d);
      @(negedge clk_i);
      start_i = 1'b1; base_addr_i = base; affine_param6_i = p6; data_i = d;
      @(negedge clk_i);
      start_i = 1'b0;
   endtask

   task automatic wait_done(input string tag, output int n);
      n = 0;
      while (done_o !== 1'b1 && n < 400) begin
         @(negedge clk_i);
         n++;
      end
      chk({tag, "_done_seen"}, done_o, 1'b1);
      chk({tag, "_busy_at_done"}, busy_o, 1'b1);
      chk({tag, "_done_after_b"}, 64'(cyc - last_b_cyc), 64'd0);
   endtask

   task automatic after_done(input string tag);
      @(negedge clk_i);
      chk({tag, "_done_pulse"}, done_o, 1'b0);
      chk({tag, "_busy_clear"}, busy_o, 1'b0);
   endtask

   task automatic check_writes(input string tag, input int awb, input int wb, input int n,
                               input logic [31:0] base, input int first,
                               input logic [5:0][63:0] d);
      logic [31:0] ea;
      chk({tag, "_aw_count"}, 64'(aw_cnt - awb), 64'(n));
      chk({tag, "_w_count"}, 64'(w_cnt - wb), 64'(n));
      for (int k = 0; k < n; k++) begin
         ea = base + 32'(8 * (first + k));
         chk($sformatf("%s_addr%0d", tag, k), addr_log[awb + k], ea);
         chk($sformatf("%s_data%0d", tag, k), data_log[wb + k], d[first + k]);
      end
   endtask

   initial begin
      logic [5:0][63:0] d1, d5, dbad;
      int awb, wb, n;
      for (int i = 0; i < 6; i++) begin
         d1[i]   = 64'(8'h11 * (i + 1));
         d5[i]   = 64'hA5A5_0000_0000_0000 | 64'(i);
         dbad[i] = 64'hDEAD_BEEF_0000_0000 | 64'(i);
      end

      // Reset state
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_done", done_o, 1'b0);
      chk("rst_err", err_o, 1'b0);
      chk("rst_awvalid", awvalid, 1'b0);
      chk("rst_wvalid", wvalid, 1'b0);
      chk("rst_bready", bready, 1'b0);
      chk("rst_awaddr", awaddr, 32'h0);
      chk("rst_wdata", wdata, 64'h0);
      chk("const_awlen", awlen, 8'h00);
      chk("const_awsize", awsize, 3'h3);
      chk("const_awburst", awburst, 2'h1);
      chk("const_wstrb", wstrb, 8'hFF);

      // 1: six words, zero-wait slave
      awb = aw_cnt; wb = w_cnt;
      start_job(32'h1000_0000, 1'b1, d1);
      chk("t1_wlast", wlast, 1'b1);
      wait_done("t1", n);
      chk("t1_cycles", 64'(n), 64'd12);
      chk("t1_err", err_o, 1'b0);
      after_done("t1");
      chk("t1_bready_idle", bready, 1'b0);
      check_writes("t1", awb, wb, 6, 32'h1000_0000, 0, d1);

      // 2: four words, X2..X5 at base+0x10
      awb = aw_cnt; wb = w_cnt;
      start_job(32'h0000_2000, 1'b0, d1);
      wait_done("t2", n);
      after_done("t2");
      check_writes("t2", awb, wb, 4, 32'h0000_2000, 2, d1);

      // 3: delayed awready, then delayed wready
      aw_delay = 3; w_delay = 0;
      awb = aw_cnt; wb = w_cnt;
      start_job(32'h0000_5000, 1'b0, d1);
      wait_done("t3a", n);
      after_done("t3a");
      check_writes("t3a", awb, wb, 4, 32'h0000_5000, 2, d1);
      aw_delay = 0; w_delay = 3;
      awb = aw_cnt; wb = w_cnt;
      start_job(32'h0000_6000, 1'b0, d5);
      wait_done("t3b", n);
      after_done("t3b");
      check_writes("t3b", awb, wb, 4, 32'h0000_6000, 2, d5);
      w_delay = 0;
      chk("t3_protocol_viol", 64'(viol), 64'd0);

      // 4: SLVERR on the second word
      err_at = b_cnt + 1;
      awb = aw_cnt; wb = w_cnt;
      start_job(32'h0000_7000, 1'b1, d1);
      wait_done("t4", n);
      chk("t4_err_at_done", err_o, 1'b1);
      after_done("t4");
      chk("t4_err_sticky", err_o, 1'b1);
      check_writes("t4", awb, wb, 6, 32'h0000_7000, 0, d1);
      err_at = -1;

      // 5: new start clears err; start while busy ignored; address wrap
      awb = aw_cnt; wb = w_cnt;
      start_job(32'hFFFF_FFF0, 1'b1, d5);
      chk("t5_err_cleared", err_o, 1'b0);
      repeat (3) @(negedge clk_i);
      start_i = 1'b1; base_addr_i = 32'h0; data_i = dbad;
      @(negedge clk_i);
      start_i = 1'b0;
      wait_done("t5", n);
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      chk("t5_start_at_done_busy", busy_o, 1'b0);
      chk("t5_start_at_done_awvalid", awvalid, 1'b0);
      check_writes("t5", awb, wb, 6, 32'hFFFF_FFF0, 0, d5);

      // 6: asynchronous reset while awvalid is held
      aw_delay = 10;
      start_job(32'h0000_4000, 1'b1, d1);
      repeat (2) @(negedge clk_i);
      chk("t6_pre_awvalid", awvalid, 1'b1);
      #2 rst_i = 1'b1;
      #1;
      chk("t6_rst_awvalid", awvalid, 1'b0);
      chk("t6_rst_wvalid", wvalid, 1'b0);
      chk("t6_rst_bready", bready, 1'b0);
      chk("t6_rst_busy", busy_o, 1'b0);
      chk("t6_rst_done", done_o, 1'b0);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      aw_delay = 0;
      awb = aw_cnt; wb = w_cnt;
      start_job(32'h0000_3000, 1'b0, d5);
      wait_done("t6", n);
      after_done("t6");
      check_writes("t6", awb, wb, 4, 32'h0000_3000, 2, d5);
      chk("final_protocol_viol", 64'(viol), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
